// File: rtl/adc_pkg.sv
// Shared types and default geometry for the ADC front-end and the downstream collect/packing stages.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } adc_state_t;

    localparam int ADC_CLK_DIV     = 4;
    localparam int ADC_SAMPLE_BITS = 12;
    localparam int ADC_CHANNELS    = 8;
    localparam int ADC_CH_BITS     = 3;
    localparam int ADC_CS_GAP      = 2;

endpackage

// File: rtl/adc_serial_frontend_sclk_gen.sv
// Half-period counter for the ADC serial clock. The counter runs while i_en is high; sclk toggles
// only while i_run is high, so a non-toggling phase (frame setup) can be timed by the same counter.
module sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_run,
    output logic o_sclk,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tick;

    assign w_tick = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            if (!i_en || w_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);

            if (!i_run)
                r_sclk <= 1'b0;
            else if (w_tick)
                r_sclk <= ~r_sclk;
        end
    end

    // Rise/fall flag the clk edge on which sclk will change, so the FSM acts on that same edge.
    assign o_sclk = r_sclk;
    assign o_tick = w_tick;
    assign o_rise = i_run && w_tick && !r_sclk;
    assign o_fall = i_run && w_tick && r_sclk;

endmodule

// File: rtl/adc_serial_frontend.sv
// SPI-style master for a multi-channel ADC: round-robin channel addressing, MSB-first capture,
// per-bit strobes for the collect stage and assembled sample words with their channel number.
module adc_serial_frontend
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = ADC_CLK_DIV,
    parameter int SAMPLE_BITS = ADC_SAMPLE_BITS,
    parameter int CHANNELS    = ADC_CHANNELS,
    parameter int CH_BITS     = ADC_CH_BITS,
    parameter int CS_GAP      = ADC_CS_GAP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   adc_sdo,
    output logic                   adc_cs_n,
    output logic                   adc_sclk,
    output logic                   adc_din,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic [CH_BITS-1:0]     sample_ch,
    output logic                   sample_valid,
    output logic                   busy
);
    localparam int BC_W = (SAMPLE_BITS > 2) ? $clog2(SAMPLE_BITS) : 1;
    localparam int GC_W = $clog2(CS_GAP + 1);

    adc_state_t             r_state;
    logic                   r_cs_n;
    logic                   r_busy;
    logic                   r_cap_pend;
    logic                   r_bit_out;
    logic                   r_bit_valid;
    logic                   r_sample_valid;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [SAMPLE_BITS-1:0] r_sample;
    logic [CH_BITS-1:0]     r_ch;
    logic [CH_BITS-1:0]     r_addr;
    logic [CH_BITS-1:0]     r_sample_ch;
    logic [BC_W-1:0]        r_bit_cnt;
    logic [GC_W-1:0]        r_gap_cnt;

    logic w_gen_en;
    logic w_gen_run;
    logic w_sclk;
    logic w_tick;
    logic w_rise;
    logic w_fall;

    assign w_gen_en  = (r_state == SETUP) || (r_state == SHIFT);
    assign w_gen_run = (r_state == SHIFT);

    sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_gen_en),
        .i_run  (w_gen_run),
        .o_sclk (w_sclk),
        .o_tick (w_tick),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cs_n         <= 1'b1;
            r_busy         <= 1'b0;
            r_cap_pend     <= 1'b0;
            r_bit_out      <= 1'b0;
            r_bit_valid    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_shift        <= '0;
            r_sample       <= '0;
            r_ch           <= '0;
            r_addr         <= '0;
            r_sample_ch    <= '0;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= '0;
        end else begin
            r_cap_pend     <= 1'b0;
            r_bit_valid    <= r_cap_pend;
            r_sample_valid <= 1'b0;
            if (r_cap_pend)
                r_bit_out <= r_shift[0];

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SETUP;
                        r_busy  <= 1'b1;
                        r_cs_n  <= 1'b0;
                        r_addr  <= r_ch;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (w_rise) begin
                        r_shift    <= {r_shift[SAMPLE_BITS-2:0], adc_sdo};
                        r_cap_pend <= 1'b1;
                    end
                    // Address shifts out MSB first and drains to zero after CH_BITS periods.
                    if (w_fall) begin
                        r_addr <= r_addr << 1;
                        if (r_bit_cnt == BC_W'(SAMPLE_BITS - 1)) begin
                            r_state        <= GAP;
                            r_cs_n         <= 1'b1;
                            r_gap_cnt      <= '0;
                            r_sample       <= r_shift;
                            r_sample_ch    <= r_ch;
                            r_sample_valid <= 1'b1;
                            r_ch           <= (r_ch == CH_BITS'(CHANNELS - 1)) ? '0 : r_ch + CH_BITS'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GC_W'(CS_GAP - 1)) begin
                        if (cont) begin
                            r_state <= SETUP;
                            r_cs_n  <= 1'b0;
                            r_addr  <= r_ch;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = w_sclk;
    assign adc_din      = r_addr[CH_BITS-1];
    assign bit_out      = r_bit_out;
    assign bit_valid    = r_bit_valid;
    assign sample       = r_sample;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_adc_serial_frontend.sv
// Directed bench for adc_serial_frontend: default build plus a CLK_DIV=2 / 8-bit build, each
// driven by a small behavioural ADC model.
module tb_adc_serial_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        adc_sdo = 1'b0;
    logic        adc_cs_n, adc_sclk, adc_din, bit_out, bit_valid, sample_valid, busy;
    logic [11:0] sample;
    logic [2:0]  sample_ch;

    logic        start2 = 1'b0;
    logic        cont2 = 1'b0;
    logic        adc_sdo2 = 1'b0;
    logic        cs_n2, sclk2, din2, bo2, bv2, sv2, busy2;
    logic [7:0]  sample2;
    logic [2:0]  sch2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_serial_frontend #(
        .CLK_DIV(4), .SAMPLE_BITS(12), .CHANNELS(8), .CH_BITS(3), .CS_GAP(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .adc_sdo(adc_sdo),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
        .bit_out(bit_out), .bit_valid(bit_valid), .sample(sample), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .busy(busy)
    );

    adc_serial_frontend #(
        .CLK_DIV(2), .SAMPLE_BITS(8), .CHANNELS(8), .CH_BITS(3), .CS_GAP(2)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cont(cont2), .adc_sdo(adc_sdo2),
        .adc_cs_n(cs_n2), .adc_sclk(sclk2), .adc_din(din2),
        .bit_out(bo2), .bit_valid(bv2), .sample(sample2), .sample_ch(sch2),
        .sample_valid(sv2), .busy(busy2)
    );

    logic [11:0] data_tab [8] = '{12'hA5C, 12'hFFF, 12'h000, 12'h801,
                                  12'h123, 12'h7E8, 12'h5A5, 12'hC3F};

    // ADC model and monitor for the default build
    int          rcnt = 0, nbits = 0, model_ch = 0, run_hi = 0, overlap = 0;
    logic [11:0] bword = '0;
    logic [2:0]  addr = '0;
    logic        prev_sclk = 1'b0, prev_cs_n = 1'b1;
    int          fr_bits[$], gap_q[$];
    logic [11:0] fr_word[$], fr_sample[$];
    logic [2:0]  fr_ch[$], fr_addr[$];

    always @(negedge clk) begin
        if (rst) begin
            rcnt = 0; nbits = 0; bword = '0; addr = '0; model_ch = 0; run_hi = 0;
            prev_sclk = 1'b0; prev_cs_n = 1'b1;
        end else begin
            if (adc_cs_n)
                rcnt = 0;
            else if (adc_sclk && !prev_sclk) begin
                if (rcnt < 3) addr = {addr[1:0], adc_din};
                rcnt++;
            end
            if (adc_cs_n && !prev_cs_n) model_ch = (model_ch + 1) % 8;
            if (bit_valid) begin
                bword = {bword[10:0], bit_out};
                nbits++;
            end
            if (sample_valid) begin
                if (bit_valid) overlap++;
                fr_bits.push_back(nbits);
                fr_word.push_back(bword);
                fr_ch.push_back(sample_ch);
                fr_sample.push_back(sample);
                fr_addr.push_back(addr);
                nbits = 0;
                bword = '0;
            end
            if (busy && adc_cs_n)
                run_hi++;
            else begin
                if (busy && run_hi > 0) gap_q.push_back(run_hi);
                run_hi = 0;
            end
            prev_sclk = adc_sclk;
            prev_cs_n = adc_cs_n;
        end
        adc_sdo = (rcnt < 12) ? data_tab[model_ch][11 - rcnt] : 1'b0;
    end

    // ADC model and monitor for the CLK_DIV=2 / 8-bit build
    int         rc2 = 0, nb2 = 0, nsv2 = 0, t2 = 0;
    logic       ps2 = 1'b0;
    logic [7:0] bw2 = '0;
    logic [7:0] w2 = 8'hC3;
    int         rise_t[$];

    always @(negedge clk) begin
        t2++;
        if (rst) begin
            rc2 = 0; nb2 = 0; nsv2 = 0; bw2 = '0; ps2 = 1'b0;
        end else begin
            if (cs_n2)
                rc2 = 0;
            else if (sclk2 && !ps2) begin
                rc2++;
                rise_t.push_back(t2);
            end
            if (bv2) begin
                bw2 = {bw2[6:0], bo2};
                nb2++;
            end
            if (sv2) nsv2++;
            ps2 = sclk2;
        end
        adc_sdo2 = (rc2 < 8) ? w2[7 - rc2] : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] smp;
        int          len;
        bit          mid_start;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int len, bad, base, gbase;

        vecs[0] = '{3'd0, 12'hA5C, 102, 1'b0};
        vecs[1] = '{3'd1, 12'hFFF, 102, 1'b1};
        vecs[2] = '{3'd2, 12'h000, 102, 1'b0};
        vecs[3] = '{3'd3, 12'h801, 102, 1'b1};

        // Reset values
        @(negedge clk);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 0);
        check("rst_din", adc_din, 0);
        check("rst_strobes", {bit_out, bit_valid, sample_valid, busy}, 0);
        check("rst_sample", {sample, sample_ch}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle with no start for 200 cycles
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0 || busy !== 1'b0 ||
                bit_valid !== 1'b0 || sample_valid !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_no_frames", fr_ch.size(), 0);

        // Narrow build: sclk period and frame length
        start2 = 1'b1;
        len = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (!busy2) break;
            len++;
        end
        #1;
        check("b2_frame_len", len, 36);
        check("b2_sample", sample2, 8'hC3);
        check("b2_sample_ch", sch2, 0);
        check("b2_bits", bw2, 8'hC3);
        check("b2_nbits", nb2, 8);
        check("b2_nsv", nsv2, 1);
        if (rise_t.size() >= 2)
            check("b2_sclk_period", rise_t[1] - rise_t[0], 4);
        else
            check("b2_sclk_rises", rise_t.size(), 8);

        // Single-start frames from the table; some get start pulses mid-frame
        foreach (vecs[k]) begin
            base = fr_ch.size();
            start = 1'b1;
            len = 0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (vecs[k].mid_start && (c == 10 || c == 50 || c == 101)) start = 1'b1;
                if (!busy) break;
                len++;
            end
            start = 1'b0;
            bad = 0;
            repeat (5) begin
                @(negedge clk);
                if (busy) bad++;
            end
            #1;
            check($sformatf("v%0d_busy_len", k), len, vecs[k].len);
            check($sformatf("v%0d_no_requeue", k), bad, 0);
            check($sformatf("v%0d_n_samples", k), fr_ch.size() - base, 1);
            if (fr_ch.size() > base) begin
                check($sformatf("v%0d_sample", k), fr_sample[base], vecs[k].smp);
                check($sformatf("v%0d_sample_ch", k), fr_ch[base], vecs[k].ch);
                check($sformatf("v%0d_bit_word", k), fr_word[base], vecs[k].smp);
                check($sformatf("v%0d_nbits", k), fr_bits[base], 12);
                check($sformatf("v%0d_din_addr", k), fr_addr[base], vecs[k].ch);
            end
        end

        // Reset at bit 6 of a frame (channel 4)
        base = fr_ch.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (nbits >= 6) break;
        end
        check("abort_at_bit6", nbits, 6);
        check("abort_sclk_high_before", adc_sclk, 1);
        rst = 1'b1;
        #1;
        check("abort_cs_n", adc_cs_n, 1);
        check("abort_sclk", adc_sclk, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        check("abort_no_sample", fr_ch.size() - base, 0);

        // Continuous run of 9 frames: channels 0..7,0 after the abort
        base = fr_ch.size();
        gbase = gap_q.size();
        start = 1'b1;
        cont = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            #1;
            if (fr_ch.size() >= base + 9) break;
        end
        cont = 1'b0;
        check("cont_n_samples", fr_ch.size() - base, 9);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("cont_end_idle", busy, 0);
        if (fr_ch.size() >= base + 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("cont%0d_ch", i), fr_ch[base + i], i % 8);
                check($sformatf("cont%0d_din_addr", i), fr_addr[base + i], i % 8);
                check($sformatf("cont%0d_sample", i), fr_sample[base + i], data_tab[i % 8]);
                check($sformatf("cont%0d_nbits", i), fr_bits[base + i], 12);
            end
        end
        check("cont_n_gaps", gap_q.size() - gbase, 8);
        for (int i = gbase; i < gap_q.size(); i++)
            check($sformatf("cont_gap%0d", i - gbase), gap_q[i], 2);
        check("no_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
